// File: rtl/hit_life_ctrl.sv
// Turns the collision flag into lives, a frame-timed invincibility window and a game-over latch.
// Optional macro HIT_BLINK_EN: when defined the plane blinks during invincibility.
module hit_life_ctrl #(
  parameter int LIVES      = 3,
  parameter int INV_FRAMES = 120,
  parameter int BLINK_DIV  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       check,
  output logic [2:0] lives,
  output logic       hit_pulse,
  output logic       invincible,
  output logic       plane_visible,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ALIVE  = 2'd1;
  localparam logic [1:0] S_INVULN = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] INV_LAST   = 8'(INV_FRAMES);

  // Reject out-of-range configurations at elaboration time.
  if (LIVES < 1 || LIVES > 7 || INV_FRAMES < 1 || INV_FRAMES > 255 ||
      BLINK_DIV < 1 || BLINK_DIV > 255) begin : g_bad_param
    $error("hit_life_ctrl: parameter out of range");
  end

  // Exposed for checkers and debug probes.
  logic [1:0] state;
  logic [7:0] inv_cnt;

`ifdef HIT_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV);
  logic [7:0] blink_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lives         <= LIVES_INIT;
      hit_pulse     <= 1'b0;
      invincible    <= 1'b0;
      plane_visible <= 1'b1;
      game_over     <= 1'b0;
      inv_cnt       <= 8'd0;
`ifdef HIT_BLINK_EN
      blink_cnt     <= 8'd0;
`endif
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ALIVE;
            lives <= LIVES_INIT;
          end
        end
        S_ALIVE: begin
          if (check) begin
            hit_pulse <= 1'b1;
            // <= 1 rather than == 1 so lives can never wrap below zero.
            if (lives <= 3'd1) begin
              state         <= S_OVER;
              lives         <= 3'd0;
              game_over     <= 1'b1;
              plane_visible <= 1'b0;
            end else begin
              state      <= S_INVULN;
              lives      <= lives - 3'd1;
              invincible <= 1'b1;
              inv_cnt    <= 8'd0;
`ifdef HIT_BLINK_EN
              plane_visible <= 1'b0;
              blink_cnt     <= 8'd0;
`endif
            end
          end
        end
        S_INVULN: begin
          if (frame_tick) begin
            inv_cnt <= inv_cnt + 8'd1;
`ifdef HIT_BLINK_EN
            if (blink_cnt + 8'd1 == BLINK_LAST) blink_cnt <= 8'd0;
            else                                blink_cnt <= blink_cnt + 8'd1;
`endif
            if (inv_cnt + 8'd1 == INV_LAST) begin
              state         <= S_ALIVE;
              invincible    <= 1'b0;
              plane_visible <= 1'b1;
            end
`ifdef HIT_BLINK_EN
            else if (blink_cnt + 8'd1 == BLINK_LAST) begin
              plane_visible <= ~plane_visible;
            end
`endif
          end
        end
        default: begin
          // Game over holds until a restart; a simultaneous check is dropped.
          if (start) begin
            state         <= S_ALIVE;
            lives         <= LIVES_INIT;
            game_over     <= 1'b0;
            plane_visible <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hit_life_ctrl.sv
// Bench for hit_life_ctrl with LIVES=3, INV_FRAMES=4, BLINK_DIV=2.
module tb_hit_life_ctrl;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ALIVE  = 2'd1;
  localparam logic [1:0] S_INVULN = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

`ifdef HIT_BLINK_EN
  localparam logic PV_HIT = 1'b0;
`else
  localparam logic PV_HIT = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       start;
  logic       check;
  logic [2:0] lives;
  logic       hit_pulse;
  logic       invincible;
  logic       plane_visible;
  logic       game_over;

  int checks = 0;
  int failures = 0;

  // Expected lives value reported alongside each accepted hit.
  logic [2:0] exp_q[$];

  hit_life_ctrl #(.LIVES(3), .INV_FRAMES(4), .BLINK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .check(check), .lives(lives), .hit_pulse(hit_pulse),
    .invincible(invincible), .plane_visible(plane_visible), .game_over(game_over)
  );

  // clock / reset
  always #5 clk = ~clk;

  // hit scoreboard: every hit_pulse must match a queued expectation
  always @(negedge clk) begin
    if (hit_pulse === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL hit_unexpected: hit_pulse=1 lives=%0d expected no hit", lives);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (lives !== e) begin
          failures++;
          $display("FAIL hit_lives: got %0d expected %0d", lives, e);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic drain_check(input string name);
    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_hits: %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dut.state, lives, hit_pulse, invincible, plane_visible, game_over} !==
        {S_IDLE, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: state=%0d lives=%0d hit=%b inv=%b pv=%b go=%b expected 0 3 0 0 1 0",
               dut.state, lives, hit_pulse, invincible, plane_visible, game_over);
    end
    do_start();
    checks++;
    if ({dut.state, lives, invincible, plane_visible, game_over} !==
        {S_ALIVE, 3'd3, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL start_state: state=%0d lives=%0d inv=%b pv=%b go=%b expected 1 3 0 1 0",
               dut.state, lives, invincible, plane_visible, game_over);
    end
  endtask

  task automatic test_single_hit();
    check = 1'b1;
    exp_q.push_back(3'd2);
    step(1);
    check = 1'b0;
    checks++;
    if ({hit_pulse, lives, invincible, plane_visible} !== {1'b1, 3'd2, 1'b1, PV_HIT}) begin
      failures++;
      $display("FAIL single_hit: hit=%b lives=%0d inv=%b pv=%b expected 1 2 1 %b",
               hit_pulse, lives, invincible, plane_visible, PV_HIT);
    end
    step(1);
    checks++;
    if (hit_pulse !== 1'b0) begin
      failures++;
      $display("FAIL single_hit_pulse_width: hit=%b expected 0", hit_pulse);
    end
    tick(); step(1);
    checks++;
    if (plane_visible !== PV_HIT) begin
      failures++;
      $display("FAIL blink_after_1: pv=%b expected %b", plane_visible, PV_HIT);
    end
    tick(); step(1);
    checks++;
    if (plane_visible !== 1'b1 || invincible !== 1'b1) begin
      failures++;
      $display("FAIL blink_after_2: pv=%b inv=%b expected 1 1", plane_visible, invincible);
    end
    tick(); step(1);
    checks++;
    if (invincible !== 1'b1 || dut.state !== S_INVULN) begin
      failures++;
      $display("FAIL inv_after_3: inv=%b state=%0d expected 1 2", invincible, dut.state);
    end
    tick();
    checks++;
    if ({invincible, plane_visible, dut.state} !== {1'b0, 1'b1, S_ALIVE}) begin
      failures++;
      $display("FAIL inv_exit: inv=%b pv=%b state=%0d expected 0 1 1",
               invincible, plane_visible, dut.state);
    end
    drain_check("single_hit");
  endtask

  task automatic test_held_check();
    do_reset();
    do_start();
    check = 1'b1;
    exp_q.push_back(3'd2);
    step(1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 3) begin
        // exit edge ignores check; the following edge takes the second hit
        checks++;
        if (dut.state !== S_ALIVE || hit_pulse !== 1'b0) begin
          failures++;
          $display("FAIL held_exit_edge: state=%0d hit=%b expected 1 0", dut.state, hit_pulse);
        end
        exp_q.push_back(3'd1);
        step(1);
        checks++;
        if ({hit_pulse, lives, dut.state} !== {1'b1, 3'd1, S_INVULN}) begin
          failures++;
          $display("FAIL held_second_hit: hit=%b lives=%0d state=%0d expected 1 1 2",
                   hit_pulse, lives, dut.state);
        end
      end else begin
        step(1);
      end
    end
    check = 1'b0;
    checks++;
    if (lives !== 3'd1 || invincible !== 1'b1) begin
      failures++;
      $display("FAIL held_lives: lives=%0d inv=%b expected 1 1", lives, invincible);
    end
    tick(); tick();
    checks++;
    if (invincible !== 1'b0) begin
      failures++;
      $display("FAIL held_window_end: inv=%b expected 0", invincible);
    end
    drain_check("held");
  endtask

  task automatic test_game_over();
    do_reset();
    do_start();
    for (int h = 0; h < 3; h++) begin
      check = 1'b1;
      exp_q.push_back(3'(2 - h));
      step(1);
      check = 1'b0;
      if (h < 2) begin
        repeat (4) tick();
        checks++;
        if (invincible !== 1'b0 || lives !== 3'(2 - h)) begin
          failures++;
          $display("FAIL go_window_%0d: inv=%b lives=%0d expected 0 %0d", h, invincible, lives, 2 - h);
        end
      end else begin
        checks++;
        if ({lives, game_over, plane_visible, invincible, dut.state} !==
            {3'd0, 1'b1, 1'b0, 1'b0, S_OVER}) begin
          failures++;
          $display("FAIL go_final_hit: lives=%0d go=%b pv=%b inv=%b state=%0d expected 0 1 0 0 3",
                   lives, game_over, plane_visible, invincible, dut.state);
        end
      end
    end
    check = 1'b1;
    tick();
    step(3);
    checks++;
    if (lives !== 3'd0 || game_over !== 1'b1 || plane_visible !== 1'b0) begin
      failures++;
      $display("FAIL go_hold: lives=%0d go=%b pv=%b expected 0 1 0", lives, game_over, plane_visible);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    check = 1'b0;
    checks++;
    if ({lives, game_over, hit_pulse, plane_visible, dut.state} !==
        {3'd3, 1'b0, 1'b0, 1'b1, S_ALIVE}) begin
      failures++;
      $display("FAIL go_restart: lives=%0d go=%b hit=%b pv=%b state=%0d expected 3 0 0 1 1",
               lives, game_over, hit_pulse, plane_visible, dut.state);
    end
    drain_check("game_over");
  endtask

  task automatic test_async_reset();
    do_reset();
    do_start();
    check = 1'b1;
    exp_q.push_back(3'd2);
    step(1);
    check = 1'b0;
    tick(); tick();
    checks++;
    if (dut.inv_cnt !== 8'd2 || invincible !== 1'b1) begin
      failures++;
      $display("FAIL arst_setup: inv_cnt=%0d inv=%b expected 2 1", dut.inv_cnt, invincible);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lives, invincible, plane_visible, game_over, dut.state} !==
        {3'd3, 1'b0, 1'b1, 1'b0, S_IDLE}) begin
      failures++;
      $display("FAIL arst_immediate: lives=%0d inv=%b pv=%b go=%b state=%0d expected 3 0 1 0 0",
               lives, invincible, plane_visible, game_over, dut.state);
    end
    step(1);
    rst_n = 1'b1;
    check = 1'b1;
    tick();
    step(3);
    check = 1'b0;
    checks++;
    if ({lives, invincible, dut.state} !== {3'd3, 1'b0, S_IDLE}) begin
      failures++;
      $display("FAIL idle_ignores_check: lives=%0d inv=%b state=%0d expected 3 0 0",
               lives, invincible, dut.state);
    end
    drain_check("async_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    start = 1'b0;
    check = 1'b0;
    test_reset();
    test_single_hit();
    test_held_check();
    test_game_over();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_life_ctrl.md
Name: hit_life_ctrl

Overview:
- Consumes the registered bullet/plane collision flag (`check`) from the collision-detect stage.
- Converts it into game consequences: one life lost per hit, a post-hit invincibility window measured in VGA frames with a blinking plane, and a game-over latch.
- Outputs feed the scoreboard/life display, the plane sprite renderer (visibility) and the top-level game FSM.

Parameters:
- LIVES, 3, lives loaded at start/restart (1..7).
- INV_FRAMES, 120, invincibility length in frames after a non-fatal hit (1..255).
- BLINK_DIV, 8, frames per visibility toggle during invincibility (1..255).

Ports:
- clk  in  1  system clock (same domain as the collision stage)
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per VGA frame
- start  in  1  one-cycle pulse: begin or restart game
- check  in  1  collision flag from the collision stage; level, may stay high many cycles
- lives  out  3  remaining lives
- hit_pulse  out  1  one-cycle pulse when a hit is accepted
- invincible  out  1  high during the invincibility window
- plane_visible  out  1  sprite enable for the player plane
- game_over  out  1  high in OVER state

Behaviour:
- All outputs are registered.
- Async reset (rst_n=0) from any state, including mid-invincibility:
  - state=IDLE, lives=LIVES, hit_pulse=0, invincible=0, plane_visible=1, game_over=0.
  - inv_cnt=0, blink_cnt=0.
- States: IDLE, ALIVE, INVULN, OVER (2-bit encoding).
- IDLE:
  - `check` and `frame_tick` are ignored.
  - `start` -> ALIVE, lives=LIVES.
- ALIVE, when check=1 on a clock edge:
  - hit_pulse=1 for exactly one cycle after that edge; lives decrements in the same edge (1-cycle latency).
  - If lives was 1 -> OVER: lives=0, game_over=1.
  - Otherwise -> INVULN: invincible=1, plane_visible=0, inv_cnt=0, blink_cnt=0.
  - A simultaneous `frame_tick` has no extra effect.
- INVULN:
  - `check` is ignored; a continuously high `check` never causes a second hit.
  - Each frame_tick: inv_cnt+1 and blink_cnt+1.
  - When blink_cnt reaches BLINK_DIV it wraps to 0 and plane_visible toggles.
  - On the frame_tick where inv_cnt+1 == INV_FRAMES -> ALIVE: invincible=0, plane_visible=1.
  - `check` in that exit cycle is ignored; `check` still high on the next edge is accepted as a hit.
- OVER:
  - game_over=1 and plane_visible=0 hold; `check` is ignored.
  - `start` -> ALIVE: lives=LIVES, game_over=0, plane_visible=1.
  - `check` in the same cycle as `start` is ignored.
- `start` in ALIVE or INVULN: ignored (no mid-game restart).
- hit_pulse is never asserted outside the ALIVE->(INVULN|OVER) edge.
- lives never underflows below 0.
- inv_cnt and blink_cnt are 8 bits.
- Counter compares use `==`; there is no wrap-around beyond INV_FRAMES.

Optional Feature:
- Macro: HIT_BLINK_EN.
- Defined: plane_visible blinks in INVULN as described above.
- Undefined:
  - blink_cnt logic is removed.
  - plane_visible=1 in IDLE, ALIVE and INVULN, and 0 only in OVER.
  - Invincibility timing is unchanged.

Test Plan:
All scenarios use LIVES=3, INV_FRAMES=4, BLINK_DIV=2, HIT_BLINK_EN defined unless noted.
1. Reset then `start` pulse -> state ALIVE, lives=3, game_over=0, plane_visible=1, invincible=0.
2. `check` high 1 cycle in ALIVE -> next cycle hit_pulse=1 (1 cycle only), lives=2, invincible=1, plane_visible=0.
   - After 2 frame_ticks: plane_visible=1.
   - On the 4th frame_tick: invincible=0, state ALIVE.
3. `check` held high continuously for 6 frames from ALIVE with lives=3:
   - Exactly one hit_pulse during INVULN.
   - Second hit accepted the cycle after the invincibility exit.
   - lives=1 after the second hit.
4. Three hits separated by full windows:
   - Third hit: lives 1->0, game_over=1, plane_visible=0, no INVULN entry.
   - Further `check` gives no hit_pulse.
   - `start` with check=1 -> lives=3, game_over=0, no hit that cycle.
5. rst_n pulled low asynchronously mid-INVULN (inv_cnt=2) -> immediately lives=3, invincible=0, plane_visible=1, state IDLE.
   - `check` in IDLE produces no response.
6. HIT_BLINK_EN undefined, one hit -> plane_visible stays 1 throughout INVULN; invincible still drops after the 4th frame_tick.
